// File: rtl/pipe_ctrl.sv
// Pipeline control: merges stage stall requests, sequences exception flushes, runs a stall watchdog.
// Optional stall/flush statistics counters are built when PIPE_CTRL_STATS_EN is defined.
module pipe_ctrl #(
   parameter logic [31:0] EXC_BASE      = 32'h0000_0000,
   parameter int unsigned STALL_TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_from_id,
   input  logic        stallreq_from_ex,
   input  logic        stallreq_from_mem,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] cp0_epc_i,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic        stall_timeout,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] flush_cnt_o
);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_STALLED,
      ST_FLUSH
   } state_t;

   localparam logic [31:0] C_EXC_INT_PC = EXC_BASE + 32'h20;
   localparam logic [31:0] C_EXC_GEN_PC = EXC_BASE + 32'h40;
   localparam logic [15:0] C_TIMEOUT    = 16'(STALL_TIMEOUT);

   state_t      r_state;
   state_t      w_state_next;
   logic [5:0]  w_stall_dec;
   logic        w_any_req;
   logic        w_take_exc;
   logic        w_stalled;
   logic [31:0] w_exc_pc;
   logic [31:0] r_new_pc;
   logic [15:0] r_wd_cnt;
   logic [16:0] w_wd_inc;
   logic        r_timeout;

   assign w_any_req  = stallreq_from_id | stallreq_from_ex | stallreq_from_mem;
   // Exceptions presented while the flush cycle is in progress are dropped.
   assign w_take_exc = (r_state != ST_FLUSH) && (excepttype_i != 32'h0);

   // Deepest requester wins: a stall freezes its own stage and everything upstream.
   always_comb begin
      w_stall_dec = 6'b000000;
      if (stallreq_from_mem)     w_stall_dec = 6'b011111;
      else if (stallreq_from_ex) w_stall_dec = 6'b001111;
      else if (stallreq_from_id) w_stall_dec = 6'b000111;
   end

   // NOTE: every output of this block gets a default first so no latch is inferred on any path.
   always_comb begin
      w_state_next = r_state;
      stall        = w_stall_dec;
      unique case (r_state)
         ST_FLUSH: begin
            w_state_next = ST_RUN;
            stall        = 6'b000000;
         end
         default: begin
            if (w_take_exc)     w_state_next = ST_FLUSH;
            else if (w_any_req) w_state_next = ST_STALLED;
            else                w_state_next = ST_RUN;
         end
      endcase
      if (rst) stall = 6'b000000;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_RUN;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_exc_pc = C_EXC_GEN_PC;
      if (excepttype_i == 32'he)      w_exc_pc = cp0_epc_i;
      else if (excepttype_i == 32'h1) w_exc_pc = C_EXC_INT_PC;
   end

   always_ff @(posedge clk) begin
      if (rst)             r_new_pc <= 32'h0;
      else if (w_take_exc) r_new_pc <= w_exc_pc;
   end

   assign flush  = (r_state == ST_FLUSH);
   assign new_pc = r_new_pc;

   assign w_stalled = (stall != 6'b000000);
   assign w_wd_inc  = {1'b0, r_wd_cnt} + 17'd1;

   // Watchdog counts consecutive stalled cycles; it only observes stall, never drives it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wd_cnt  <= 16'h0;
         r_timeout <= 1'b0;
      end else begin
         if (!w_stalled)               r_wd_cnt <= 16'h0;
         else if (r_wd_cnt != 16'hFFFF) r_wd_cnt <= w_wd_inc[15:0];
         if (w_stalled && (w_wd_inc >= {1'b0, C_TIMEOUT})) r_timeout <= 1'b1;
      end
   end

   assign stall_timeout = r_timeout;

`ifdef PIPE_CTRL_STATS_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_flush_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= 32'h0;
         r_flush_cnt <= 32'h0;
      end else begin
         if (w_stalled && (r_stall_cnt != 32'hFFFF_FFFF))  r_stall_cnt <= r_stall_cnt + 32'd1;
         if (w_take_exc && (r_flush_cnt != 32'hFFFF_FFFF)) r_flush_cnt <= r_flush_cnt + 32'd1;
      end
   end

   assign stall_cnt_o = r_stall_cnt;
   assign flush_cnt_o = r_flush_cnt;
`else
   assign stall_cnt_o = 32'h0;
   assign flush_cnt_o = 32'h0;
`endif

endmodule
